// File: rtl/imem_boot_arbiter.sv
// Boot loader / arbiter for a single-port instruction memory: streams an image in, then hands the port to fetch.
// Optional build macro IMEM_BOOT_CHECKSUM_EN adds an expected-sum check on the final beat.
module imem_boot_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 6,
  parameter int RUN_DLY = 2
) (
  input  logic          clk,
  input  logic          res,
  input  logic          boot_start,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [DW-1:0] host_data,
  input  logic          host_last,
  input  logic [AW-1:0] fetch_adr,
  output logic [DW-1:0] fetch_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_run,
  output logic          boot_done,
  output logic          boot_err,
  output logic [AW:0]   words_loaded
`ifdef IMEM_BOOT_CHECKSUM_EN
  ,
  input  logic [DW-1:0] exp_sum,
  output logic [DW-1:0] load_sum
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [AW-1:0] PTR_MAX = '1;
  localparam logic [AW:0]   WL_MAX  = {1'b1, {AW{1'b0}}};

  logic [2:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   wl;
  logic [3:0]    dly;
  logic          accept;
  logic          sum_ok;

  // A restart request in LOAD beats a simultaneous beat: that word is dropped.
  assign accept = (state == S_LOAD) && host_valid && !boot_start;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DW-1:0] sum;
  assign sum_ok   = ((sum + host_data) == exp_sum);
  assign load_sum = sum;
`else
  assign sum_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      wl     <= '0;
      dly    <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_RUN, S_ERR, S_LOAD: begin
          if (boot_start) begin
            state  <= S_LOAD;
            wr_ptr <= '0;
            wl     <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum    <= '0;
`endif
          end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wl != WL_MAX) wl <= wl + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum    <= sum + host_data;
`endif
            if (host_last) begin
              state <= sum_ok ? S_DRAIN : S_ERR;
              dly   <= 4'(RUN_DLY);
            end else if (wr_ptr == PTR_MAX) begin
              state <= S_ERR;
            end
          end
        end
        S_DRAIN: begin
          dly <= dly - 4'd1;
          if (dly == 4'd1) state <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Port ownership is decided purely by state: fetch owns the address only in RUN.
  assign host_ready   = (state == S_LOAD);
  assign mem_we       = accept;
  assign mem_adr      = (state == S_RUN) ? fetch_adr : wr_ptr;
  assign mem_wdata    = host_data;
  assign fetch_data   = (state == S_RUN) ? mem_rdata : '0;
  assign core_run     = (state == S_RUN);
  assign boot_done    = (state == S_RUN);
  assign boot_err     = (state == S_ERR);
  assign words_loaded = wl;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Self-checking bench for imem_boot_arbiter: timestamp-based load/run model plus directed literal checks.
// Also exercises the IMEM_BOOT_CHECKSUM_EN build when that macro is defined.
module tb_imem_boot_arbiter;

  localparam int RUN_DLY = 2;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        boot_start = 1'b0;
  logic        host_valid = 1'b0;
  logic [31:0] host_data = '0;
  logic        host_last = 1'b0;
  logic [5:0]  fetch_adr = '0;

  logic        host_ready, mem_we, core_run, boot_done, boot_err;
  logic [5:0]  mem_adr;
  logic [31:0] mem_wdata, mem_rdata, fetch_data;
  logic [6:0]  words_loaded;

  logic        host_ready3, mem_we3, core_run3, boot_done3, boot_err3;
  logic [2:0]  mem_adr3, fetch_adr3;
  logic [31:0] mem_wdata3, mem_rdata3, fetch_data3;
  logic [3:0]  words3;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] exp_sum = '0;
  logic [31:0] load_sum, load_sum3;
  logic [31:0] acc = '0;
  logic [31:0] bias = '0;
`endif

  logic [31:0] mem  [64] = '{default: 32'h0};
  logic [31:0] mem3 [8]  = '{default: 32'h0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign fetch_adr3 = fetch_adr[2:0];
  assign mem_rdata  = mem[mem_adr];
  assign mem_rdata3 = mem3[mem_adr3];

  always @(posedge clk) begin
    if (mem_we)  mem[mem_adr]   <= mem_wdata;
    if (mem_we3) mem3[mem_adr3] <= mem_wdata3;
  end

  imem_boot_arbiter #(.DW(32), .AW(6), .RUN_DLY(RUN_DLY)) dut (
    .clk(clk), .res(res), .boot_start(boot_start), .host_valid(host_valid),
    .host_ready(host_ready), .host_data(host_data), .host_last(host_last),
    .fetch_adr(fetch_adr), .fetch_data(fetch_data), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_run(core_run), .boot_done(boot_done), .boot_err(boot_err),
    .words_loaded(words_loaded)
`ifdef IMEM_BOOT_CHECKSUM_EN
    , .exp_sum(exp_sum), .load_sum(load_sum)
`endif
  );

  imem_boot_arbiter #(.DW(32), .AW(3), .RUN_DLY(RUN_DLY)) dut3 (
    .clk(clk), .res(res), .boot_start(boot_start), .host_valid(host_valid),
    .host_ready(host_ready3), .host_data(host_data), .host_last(host_last),
    .fetch_adr(fetch_adr3), .fetch_data(fetch_data3), .mem_we(mem_we3),
    .mem_adr(mem_adr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .core_run(core_run3), .boot_done(boot_done3), .boot_err(boot_err3),
    .words_loaded(words3)
`ifdef IMEM_BOOT_CHECKSUM_EN
    , .exp_sum(exp_sum), .load_sum(load_sum3)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (main 64-word instance) ----------------
  // Load progress is a word count; RUN is "the cycle index at which the core starts".
  logic [31:0] img [64] = '{default: 32'h0};
  int  cyc = 0;
  int  run_at = -1;
  int  m_words = 0;
  bit  m_load = 1'b0;
  bit  m_err = 1'b0;
  bit  m_ok = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] m_sum = '0;
`endif

  always @(negedge clk) begin
    bit running, draining, exp_we, bad_sum;
    int ptr;
    running  = (run_at >= 0) && (cyc >= run_at);
    draining = (run_at >= 0) && (cyc < run_at) && !m_load;
    exp_we   = m_load && host_valid && !boot_start;
    if (m_ok) begin
      check("host_ready", 64'(host_ready), 64'(m_load));
      check("core_run", 64'(core_run), 64'(running));
      check("boot_done", 64'(boot_done), 64'(running));
      check("boot_err", 64'(boot_err), 64'(m_err));
      check("mem_we", 64'(mem_we), 64'(exp_we));
      check("mem_adr", 64'(mem_adr), running ? 64'(fetch_adr) : 64'(m_words % 64));
      if (exp_we) check("mem_wdata", 64'(mem_wdata), 64'(host_data));
      check("fetch_data", 64'(fetch_data), running ? 64'(img[fetch_adr]) : 64'(0));
      check("words_loaded", 64'(words_loaded), 64'(m_words));
`ifdef IMEM_BOOT_CHECKSUM_EN
      check("load_sum", 64'(load_sum), 64'(m_sum));
`endif
    end
    if (res) begin
      m_load = 1'b0; m_err = 1'b0; run_at = -1; m_words = 0; m_ok = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
      m_sum = '0;
`endif
    end else if (boot_start && !draining) begin
      m_load = 1'b1; m_err = 1'b0; run_at = -1; m_words = 0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      m_sum = '0;
`endif
    end else if (exp_we) begin
      ptr = m_words % 64;
      img[ptr] = host_data;
      if (m_words < 64) m_words++;
      bad_sum = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      bad_sum = ((m_sum + host_data) != exp_sum);
      m_sum = m_sum + host_data;
`endif
      if (host_last) begin
        m_load = 1'b0;
        if (bad_sum) m_err = 1'b1;
        else run_at = cyc + RUN_DLY + 1;
      end else if (ptr == 63) begin
        m_load = 1'b0;
        m_err = 1'b1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    boot_start = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
    acc = '0;
`endif
    tick();
    boot_start = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit last);
    host_valid = v;
    host_data  = d;
    host_last  = last;
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (v) begin
      if (last) exp_sum = acc + d + bias;
      acc = acc + d;
    end
`endif
    tick();
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (!core_run && n < 20) begin
      tick();
      n++;
    end
    if (!core_run) check("run_timeout", 64'(0), 64'(1));
  endtask

  logic [31:0] prog [6] = '{32'h2009000B, 32'h200A000C, 32'h200B000F,
                            32'h014B6020, 32'hAD2C0000, 32'h8D2A0000};
  logic [31:0] gap  [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    int n;
    tick();
    tick();
    res = 1'b0;
    check("rst_host_ready", 64'(host_ready), 64'(0));
    check("rst_core_run", 64'(core_run), 64'(0));
    check("rst_words", 64'(words_loaded), 64'(0));
    check("rst_boot_err", 64'(boot_err), 64'(0));
    check("rst_boot_done", 64'(boot_done), 64'(0));

    // Back-to-back 6-word image.
    start();
    for (int i = 0; i < 6; i++) drive(1'b1, prog[i], i == 5);
    wait_run(n);
    check("run_latency", 64'(n), 64'(2));
    check("words_6", 64'(words_loaded), 64'(6));
    check("boot_done_6", 64'(boot_done), 64'(1));
    for (int i = 0; i < 6; i++) check("img_word", 64'(mem[i]), 64'(prog[i]));

    // Fetch path in RUN; host traffic must not write.
    fetch_adr  = 6'd3;
    host_valid = 1'b1;
    host_data  = 32'hDEADBEEF;
    #1;
    check("fetch_3", 64'(fetch_data), 64'h014B6020);
    check("run_no_we", 64'(mem_we), 64'(0));
    tick();
    host_valid = 1'b0;
    check("run_mem3_kept", 64'(mem[3]), 64'h014B6020);

    // Gapped load.
    start();
    for (int i = 0; i < 7; i++)
      drive(i % 2 == 0, (i % 2 == 0) ? gap[i/2] : (32'hBAD00000 | 32'(i)), i == 6);
    wait_run(n);
    for (int i = 0; i < 4; i++) check("gap_word", 64'(mem[i]), 64'(gap[i]));
    check("gap_mem4_kept", 64'(mem[4]), 64'hAD2C0000);
    check("gap_words", 64'(words_loaded), 64'(4));

    // Overflow on the 8-deep instance.
    start();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0);
    check("ovf_err", 64'(boot_err3), 64'(1));
    check("ovf_run", 64'(core_run3), 64'(0));
    check("ovf_done", 64'(boot_done3), 64'(0));
    check("ovf_fetch", 64'(fetch_data3), 64'(0));
    check("ovf_mem7", 64'(mem3[7]), 64'h107);
    check("ovf_words", 64'(words3), 64'(8));
`ifdef IMEM_BOOT_CHECKSUM_EN
    check("ovf_sum", 64'(load_sum3), 64'h81C);
`endif
    start();
    check("ovf_reload_ready", 64'(host_ready3), 64'(1));
    check("ovf_reload_err", 64'(boot_err3), 64'(0));
    check("ovf_reload_adr", 64'(mem_adr3), 64'(0));
    check("ovf_reload_words", 64'(words3), 64'(0));

    // Reset in the middle of a load.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h201 + 32'(i), 1'b0);
    res = 1'b1;
    tick();
    res = 1'b0;
    check("midrst_ready", 64'(host_ready), 64'(0));
    check("midrst_words", 64'(words_loaded), 64'(0));
    check("midrst_ready3", 64'(host_ready3), 64'(0));

    // Restart from RUN.
    start();
    drive(1'b1, 32'h301, 1'b0);
    drive(1'b1, 32'h302, 1'b1);
    wait_run(n);
    start();
    check("restart_run", 64'(core_run), 64'(0));
    check("restart_ready", 64'(host_ready), 64'(1));
    host_valid = 1'b1;
    host_data  = 32'h3A0;
    host_last  = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
    exp_sum = 32'h3A0;
`endif
    #1;
    check("restart_we", 64'(mem_we), 64'(1));
    check("restart_adr", 64'(mem_adr), 64'(0));
    tick();
    host_valid = 1'b0;
    host_last  = 1'b0;
    wait_run(n);
    check("restart_mem0", 64'(mem[0]), 64'h3A0);
    check("restart_words", 64'(words_loaded), 64'(1));

`ifdef IMEM_BOOT_CHECKSUM_EN
    start();
    for (int i = 1; i <= 3; i++) drive(1'b1, 32'(i), i == 3);
    wait_run(n);
    check("sum_ok_run", 64'(boot_done), 64'(1));
    check("sum_ok_val", 64'(load_sum), 64'(6));
    bias = 32'd1;
    start();
    for (int i = 1; i <= 3; i++) drive(1'b1, 32'(i), i == 3);
    bias = 32'd0;
    tick();
    check("sum_bad_err", 64'(boot_err), 64'(1));
    check("sum_bad_run", 64'(core_run), 64'(0));
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
